// File: rtl/branch_update_queue_if.sv
// Shared BUQ types and the IF/EXE/ROB <-> branch update queue bundle.
// Slave side is the queue; master side is the pipeline driving it.
package buq_pkg;
    typedef logic [31:0] pc_t;
    typedef logic [7:0]  BHSR_t;
endpackage

interface branch_update_queue_if #(
    parameter int BUQ_TAG_W = 3
);
    import buq_pkg::*;

    logic                 enq0_valid;
    pc_t                  enq0_pc;
    logic                 enq0_pred_taken;
    BHSR_t                enq0_bhsr;
    logic                 enq1_valid;
    pc_t                  enq1_pc;
    logic                 enq1_pred_taken;
    BHSR_t                enq1_bhsr;
    logic                 enq0_ready;
    logic                 enq1_ready;
    logic [BUQ_TAG_W-1:0] enq0_tag;
    logic [BUQ_TAG_W-1:0] enq1_tag;
    logic                 resolve_valid;
    logic [BUQ_TAG_W-1:0] resolve_tag;
    logic                 resolve_taken;
    logic                 commit_valid;
    logic                 flush_all;
    logic                 exe_cond_valid;
    logic                 exe_cond_miss_prediction;
    BHSR_t                exe_cond_bhsr;
    logic                 exe_cond_branch_taken;
    pc_t                  exe_cond_branch_addr;
    logic                 buq_full;
    logic                 buq_empty;

    modport master (
        output enq0_valid, enq0_pc, enq0_pred_taken, enq0_bhsr,
        output enq1_valid, enq1_pc, enq1_pred_taken, enq1_bhsr,
        output resolve_valid, resolve_tag, resolve_taken,
        output commit_valid, flush_all,
        input  enq0_ready, enq1_ready, enq0_tag, enq1_tag,
        input  exe_cond_valid, exe_cond_miss_prediction,
        input  exe_cond_bhsr, exe_cond_branch_taken,
        input  exe_cond_branch_addr, buq_full, buq_empty
    );

    modport slave (
        input  enq0_valid, enq0_pc, enq0_pred_taken, enq0_bhsr,
        input  enq1_valid, enq1_pc, enq1_pred_taken, enq1_bhsr,
        input  resolve_valid, resolve_tag, resolve_taken,
        input  commit_valid, flush_all,
        output enq0_ready, enq1_ready, enq0_tag, enq1_tag,
        output exe_cond_valid, exe_cond_miss_prediction,
        output exe_cond_bhsr, exe_cond_branch_taken,
        output exe_cond_branch_addr, buq_full, buq_empty
    );
endinterface

// File: rtl/branch_update_queue.sv
// Branch update queue: tags in-flight conditional branches, feeds gshare.
// Optional FALCO_BUQ_STATS_EN adds saturating resolve/mispredict counters.
module branch_update_queue
    import buq_pkg::*;
#(
    parameter int BUQ_DEPTH = 8,
    parameter int BUQ_TAG_W = 3
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef FALCO_BUQ_STATS_EN
    output logic [31:0] stat_resolve_cnt,
    output logic [31:0] stat_mispredict_cnt,
`endif
    branch_update_queue_if.slave bus
);
    typedef logic [BUQ_TAG_W:0]   ptr_t;
    typedef logic [BUQ_TAG_W-1:0] tag_t;

    localparam ptr_t ONE   = ptr_t'(1);
    localparam ptr_t TWO   = ptr_t'(2);
    localparam ptr_t LIM1  = ptr_t'(BUQ_DEPTH - 2);

    ptr_t                 head_q, tail_q, head_n, tail_n;
    ptr_t                 used, sq_tail;
    logic [BUQ_DEPTH-1:0] vld_q, vld_n;
    logic [BUQ_DEPTH-1:0] pred_q;
    pc_t                  pc_q   [BUQ_DEPTH];
    BHSR_t                bhsr_q [BUQ_DEPTH];

    tag_t head_tag, tail_tag, tail_tag1, res_off, age;
    logic full, empty;
    logic acc0, acc1, hit, mis;
    logic do_flush, do_sq, do_enq, do_commit, upd;

    logic  out_valid, out_miss, out_taken;
    BHSR_t out_bhsr;
    pc_t   out_addr;

    assign head_tag  = head_q[BUQ_TAG_W-1:0];
    assign tail_tag  = tail_q[BUQ_TAG_W-1:0];
    assign tail_tag1 = tail_tag + tag_t'(1);

    assign empty = head_q == tail_q;
    assign full  = (head_tag == tail_tag) &&
                   (head_q[BUQ_TAG_W] != tail_q[BUQ_TAG_W]);
    assign used  = tail_q - head_q;

    assign bus.enq0_ready = !full;
    assign bus.enq1_ready = used <= LIM1;
    assign bus.enq0_tag   = tail_tag;
    assign bus.enq1_tag   = tail_tag1;
    assign bus.buq_full   = full;
    assign bus.buq_empty  = empty;

    assign acc0 = bus.enq0_valid && !full;
    assign acc1 = acc0 && bus.enq1_valid && bus.enq1_ready;

    assign hit = bus.resolve_valid && vld_q[bus.resolve_tag];
    assign mis = hit &&
                 (bus.resolve_taken ^ pred_q[bus.resolve_tag]);

    assign do_flush  = bus.flush_all;
    assign do_sq     = mis && !bus.flush_all;
    assign do_enq    = acc0 && !bus.flush_all && !mis;
    assign do_commit = bus.commit_valid && !empty;
    assign upd       = hit && !bus.flush_all;

    // Age of the resolving entry relative to head locates its wrap bit.
    assign res_off = bus.resolve_tag - head_tag;
    assign sq_tail = head_q + {1'b0, res_off} + ONE;

    always_comb begin
        head_n = do_commit ? head_q + ONE : head_q;
        tail_n = tail_q;
        vld_n  = vld_q;
        age    = '0;
        if (do_commit)
            vld_n[head_tag] = 1'b0;
        unique case (1'b1)
            do_flush: begin
                tail_n = head_n;
                vld_n  = '0;
            end
            do_sq: begin
                tail_n = sq_tail;
                for (int i = 0; i < BUQ_DEPTH; i++) begin
                    age = tag_t'(i) - head_tag;
                    if (age > res_off)
                        vld_n[i] = 1'b0;
                end
            end
            do_enq: begin
                vld_n[tail_tag] = 1'b1;
                if (acc1)
                    vld_n[tail_tag1] = 1'b1;
                tail_n = tail_q + (acc1 ? TWO : ONE);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            vld_q  <= '0;
        end else begin
            head_q <= head_n;
            tail_q <= tail_n;
            vld_q  <= vld_n;
        end
    end

    // Payload needs no reset: it is only read behind a valid bit.
    always_ff @(posedge clk) begin
        if (do_enq) begin
            pc_q[tail_tag]   <= bus.enq0_pc;
            pred_q[tail_tag] <= bus.enq0_pred_taken;
            bhsr_q[tail_tag] <= bus.enq0_bhsr;
            if (acc1) begin
                pc_q[tail_tag1]   <= bus.enq1_pc;
                pred_q[tail_tag1] <= bus.enq1_pred_taken;
                bhsr_q[tail_tag1] <= bus.enq1_bhsr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_miss  <= 1'b0;
            out_taken <= 1'b0;
            out_bhsr  <= '0;
            out_addr  <= '0;
        end else begin
            out_valid <= upd;
            if (upd) begin
                out_miss  <= mis;
                out_taken <= bus.resolve_taken;
                out_bhsr  <= bhsr_q[bus.resolve_tag];
                out_addr  <= pc_q[bus.resolve_tag];
            end
        end
    end

    assign bus.exe_cond_valid           = out_valid;
    assign bus.exe_cond_miss_prediction = out_miss;
    assign bus.exe_cond_branch_taken    = out_taken;
    assign bus.exe_cond_bhsr            = out_bhsr;
    assign bus.exe_cond_branch_addr     = out_addr;

`ifdef FALCO_BUQ_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_resolve_cnt    <= '0;
            stat_mispredict_cnt <= '0;
        end else if (out_valid) begin
            if (stat_resolve_cnt != '1)
                stat_resolve_cnt <= stat_resolve_cnt + 32'd1;
            if (out_miss && stat_mispredict_cnt != '1)
                stat_mispredict_cnt <= stat_mispredict_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_branch_update_queue.sv
// Directed bench for branch_update_queue.
// Define FALCO_BUQ_STATS_EN to also exercise the statistics counters.
module tb_branch_update_queue;
    import buq_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   vecs = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    branch_update_queue_if #(.BUQ_TAG_W(3)) bus();

`ifdef FALCO_BUQ_STATS_EN
    logic [31:0] s_res, s_mis;
`endif

    branch_update_queue #(
        .BUQ_DEPTH(8),
        .BUQ_TAG_W(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef FALCO_BUQ_STATS_EN
        .stat_resolve_cnt(s_res),
        .stat_mispredict_cnt(s_mis),
`endif
        .bus(bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.enq0_valid = 0; bus.enq0_pc = '0;
        bus.enq0_pred_taken = 0; bus.enq0_bhsr = '0;
        bus.enq1_valid = 0; bus.enq1_pc = '0;
        bus.enq1_pred_taken = 0; bus.enq1_bhsr = '0;
        bus.resolve_valid = 0; bus.resolve_tag = '0;
        bus.resolve_taken = 0;
        bus.commit_valid = 0; bus.flush_all = 0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        #1;
        vecs++; if (bus.exe_cond_valid !== 1'b0) begin errs++; $display("FAIL rst_valid got %0b want 0", bus.exe_cond_valid); end
        vecs++; if (bus.exe_cond_branch_addr !== 32'h0) begin errs++; $display("FAIL rst_addr got %0h want 0", bus.exe_cond_branch_addr); end
        vecs++; if (bus.buq_empty !== 1'b1) begin errs++; $display("FAIL rst_empty got %0b want 1", bus.buq_empty); end
        vecs++; if (bus.buq_full !== 1'b0) begin errs++; $display("FAIL rst_full got %0b want 0", bus.buq_full); end
        vecs++; if (bus.enq1_ready !== 1'b1) begin errs++; $display("FAIL rst_enq1_ready got %0b want 1", bus.enq1_ready); end
        tick();
        rst_n = 1;
    endtask

    task automatic test_basic();
        do_reset();
        bus.enq0_valid = 1; bus.enq0_pc = 32'h100;
        bus.enq0_pred_taken = 1; bus.enq0_bhsr = 8'h05;
        #1;
        vecs++; if (bus.enq0_tag !== 3'd0) begin errs++; $display("FAIL basic_tag got %0d want 0", bus.enq0_tag); end
        tick(); idle();
        bus.resolve_valid = 1; bus.resolve_tag = 3'd0; bus.resolve_taken = 1;
        tick(); idle();
        vecs++; if (bus.exe_cond_valid !== 1'b1) begin errs++; $display("FAIL basic_valid got %0b want 1", bus.exe_cond_valid); end
        vecs++; if (bus.exe_cond_miss_prediction !== 1'b0) begin errs++; $display("FAIL basic_miss got %0b want 0", bus.exe_cond_miss_prediction); end
        vecs++; if (bus.exe_cond_branch_addr !== 32'h100) begin errs++; $display("FAIL basic_addr got %0h want 100", bus.exe_cond_branch_addr); end
        vecs++; if (bus.exe_cond_bhsr !== 8'h05) begin errs++; $display("FAIL basic_bhsr got %0h want 05", bus.exe_cond_bhsr); end
        vecs++; if (bus.exe_cond_branch_taken !== 1'b1) begin errs++; $display("FAIL basic_taken got %0b want 1", bus.exe_cond_branch_taken); end
        tick();
        vecs++; if (bus.exe_cond_valid !== 1'b0) begin errs++; $display("FAIL basic_pulse got %0b want 0", bus.exe_cond_valid); end
    endtask

    task automatic test_squash();
        do_reset();
        bus.enq0_valid = 1; bus.enq0_pc = 32'h200; bus.enq0_bhsr = 8'h10;
        bus.enq1_valid = 1; bus.enq1_pc = 32'h204; bus.enq1_bhsr = 8'h11;
        #1;
        vecs++; if (bus.enq1_tag !== 3'd1) begin errs++; $display("FAIL sq_tag1 got %0d want 1", bus.enq1_tag); end
        tick();
        bus.enq0_pc = 32'h208; bus.enq0_bhsr = 8'h12;
        bus.enq1_pc = 32'h20c; bus.enq1_bhsr = 8'h13;
        #1;
        vecs++; if (bus.enq0_tag !== 3'd2) begin errs++; $display("FAIL sq_tag2 got %0d want 2", bus.enq0_tag); end
        vecs++; if (bus.enq1_tag !== 3'd3) begin errs++; $display("FAIL sq_tag3 got %0d want 3", bus.enq1_tag); end
        tick(); idle();
        bus.resolve_valid = 1; bus.resolve_tag = 3'd1; bus.resolve_taken = 1;
        bus.enq0_valid = 1; bus.enq0_pc = 32'h300;
        tick(); idle();
        vecs++; if (bus.exe_cond_valid !== 1'b1) begin errs++; $display("FAIL sq_valid got %0b want 1", bus.exe_cond_valid); end
        vecs++; if (bus.exe_cond_miss_prediction !== 1'b1) begin errs++; $display("FAIL sq_miss got %0b want 1", bus.exe_cond_miss_prediction); end
        vecs++; if (bus.exe_cond_branch_addr !== 32'h204) begin errs++; $display("FAIL sq_addr got %0h want 204", bus.exe_cond_branch_addr); end
        vecs++; if (bus.exe_cond_bhsr !== 8'h11) begin errs++; $display("FAIL sq_bhsr got %0h want 11", bus.exe_cond_bhsr); end
        vecs++; if (bus.enq0_tag !== 3'd2) begin errs++; $display("FAIL sq_tail got %0d want 2", bus.enq0_tag); end
        bus.resolve_valid = 1; bus.resolve_tag = 3'd2; bus.resolve_taken = 0;
        tick(); idle();
        vecs++; if (bus.exe_cond_valid !== 1'b0) begin errs++; $display("FAIL sq_dead got %0b want 0", bus.exe_cond_valid); end
        bus.resolve_valid = 1; bus.resolve_tag = 3'd0; bus.resolve_taken = 0;
        tick(); idle();
        vecs++; if (bus.exe_cond_valid !== 1'b1) begin errs++; $display("FAIL sq_old_valid got %0b want 1", bus.exe_cond_valid); end
        vecs++; if (bus.exe_cond_branch_addr !== 32'h200) begin errs++; $display("FAIL sq_old_addr got %0h want 200", bus.exe_cond_branch_addr); end
    endtask

    task automatic test_full();
        do_reset();
        bus.enq0_pred_taken = 1; bus.enq1_pred_taken = 1;
        for (int i = 0; i < 3; i++) begin
            bus.enq0_valid = 1; bus.enq1_valid = 1;
            tick();
        end
        bus.enq1_valid = 0;
        tick(); idle();
        vecs++; if (bus.enq0_ready !== 1'b1) begin errs++; $display("FAIL f7_rdy0 got %0b want 1", bus.enq0_ready); end
        vecs++; if (bus.enq1_ready !== 1'b0) begin errs++; $display("FAIL f7_rdy1 got %0b want 0", bus.enq1_ready); end
        vecs++; if (bus.buq_full !== 1'b0) begin errs++; $display("FAIL f7_full got %0b want 0", bus.buq_full); end
        bus.enq0_valid = 1;
        tick();
        vecs++; if (bus.buq_full !== 1'b1) begin errs++; $display("FAIL f8_full got %0b want 1", bus.buq_full); end
        vecs++; if (bus.enq0_ready !== 1'b0) begin errs++; $display("FAIL f8_rdy0 got %0b want 0", bus.enq0_ready); end
        tick(); idle();
        vecs++; if (bus.buq_full !== 1'b1) begin errs++; $display("FAIL f8_drop got %0b want 1", bus.buq_full); end
        bus.commit_valid = 1;
        tick(); idle();
        vecs++; if (bus.buq_full !== 1'b0) begin errs++; $display("FAIL fc_full got %0b want 0", bus.buq_full); end
        vecs++; if (bus.enq0_ready !== 1'b1) begin errs++; $display("FAIL fc_rdy0 got %0b want 1", bus.enq0_ready); end
        vecs++; if (bus.enq1_ready !== 1'b0) begin errs++; $display("FAIL fc_rdy1 got %0b want 0", bus.enq1_ready); end
        vecs++; if (bus.enq0_tag !== 3'd0) begin errs++; $display("FAIL fc_tag got %0d want 0", bus.enq0_tag); end
    endtask

    task automatic test_wrap();
        logic [2:0] want;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            want = 3'(i % 8);
            vecs++; if (bus.enq0_tag !== want) begin errs++; $display("FAIL wrap_tag[%0d] got %0d want %0d", i, bus.enq0_tag, want); end
            bus.enq0_valid = 1;
            tick(); idle();
            vecs++; if (bus.buq_empty !== 1'b0) begin errs++; $display("FAIL wrap_nempty[%0d] got %0b want 0", i, bus.buq_empty); end
            bus.commit_valid = 1;
            tick(); idle();
            vecs++; if (bus.buq_empty !== 1'b1 || bus.buq_full !== 1'b0) begin errs++; $display("FAIL wrap_flags[%0d] got e%0b f%0b want e1 f0", i, bus.buq_empty, bus.buq_full); end
        end
    endtask

    task automatic test_flush();
        do_reset();
        bus.enq0_valid = 1; bus.enq1_valid = 1;
        tick(); idle();
        bus.flush_all = 1; bus.commit_valid = 1;
        bus.resolve_valid = 1; bus.resolve_tag = 3'd1;
        bus.enq0_valid = 1;
        tick(); idle();
        vecs++; if (bus.exe_cond_valid !== 1'b0) begin errs++; $display("FAIL fl_valid got %0b want 0", bus.exe_cond_valid); end
        vecs++; if (bus.buq_empty !== 1'b1) begin errs++; $display("FAIL fl_empty got %0b want 1", bus.buq_empty); end
        vecs++; if (bus.enq0_tag !== 3'd1) begin errs++; $display("FAIL fl_tag got %0d want 1", bus.enq0_tag); end
    endtask

    task automatic test_commit_resolve();
        do_reset();
        bus.enq0_valid = 1; bus.enq0_pc = 32'h300; bus.enq0_bhsr = 8'h33;
        tick(); idle();
        bus.commit_valid = 1;
        bus.resolve_valid = 1; bus.resolve_tag = 3'd0; bus.resolve_taken = 0;
        tick(); idle();
        vecs++; if (bus.exe_cond_valid !== 1'b1) begin errs++; $display("FAIL cr_valid got %0b want 1", bus.exe_cond_valid); end
        vecs++; if (bus.exe_cond_branch_addr !== 32'h300) begin errs++; $display("FAIL cr_addr got %0h want 300", bus.exe_cond_branch_addr); end
        vecs++; if (bus.buq_empty !== 1'b1) begin errs++; $display("FAIL cr_empty got %0b want 1", bus.buq_empty); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.enq0_valid = 1; bus.enq0_pc = 32'h400; bus.enq0_pred_taken = 1;
        tick(); idle();
        bus.resolve_valid = 1; bus.resolve_tag = 3'd0; bus.resolve_taken = 0;
        tick(); idle();
        vecs++; if (bus.exe_cond_miss_prediction !== 1'b1) begin errs++; $display("FAIL rm_miss got %0b want 1", bus.exe_cond_miss_prediction); end
        rst_n = 0;
        #1;
        vecs++; if (bus.exe_cond_valid !== 1'b0) begin errs++; $display("FAIL rm_valid got %0b want 0", bus.exe_cond_valid); end
        vecs++; if (bus.buq_empty !== 1'b1) begin errs++; $display("FAIL rm_empty got %0b want 1", bus.buq_empty); end
        tick();
        rst_n = 1;
        bus.resolve_valid = 1; bus.resolve_tag = 3'd0;
        tick(); idle();
        vecs++; if (bus.exe_cond_valid !== 1'b0) begin errs++; $display("FAIL rm_stale got %0b want 0", bus.exe_cond_valid); end
    endtask

`ifdef FALCO_BUQ_STATS_EN
    task automatic test_stats();
        do_reset();
        bus.enq0_valid = 1; bus.enq0_pred_taken = 1;
        bus.enq1_valid = 1; bus.enq1_pred_taken = 1;
        tick();
        bus.enq1_valid = 0;
        tick(); idle();
        bus.resolve_valid = 1; bus.resolve_tag = 3'd2; bus.resolve_taken = 1;
        tick();
        bus.resolve_tag = 3'd0;
        tick();
        bus.resolve_tag = 3'd1; bus.resolve_taken = 0;
        tick(); idle();
        tick();
        vecs++; if (s_res !== 32'd3) begin errs++; $display("FAIL st_res got %0d want 3", s_res); end
        vecs++; if (s_mis !== 32'd1) begin errs++; $display("FAIL st_mis got %0d want 1", s_mis); end
        rst_n = 0;
        #1;
        vecs++; if (s_res !== 32'd0) begin errs++; $display("FAIL st_res_rst got %0d want 0", s_res); end
        vecs++; if (s_mis !== 32'd0) begin errs++; $display("FAIL st_mis_rst got %0d want 0", s_mis); end
        tick();
        rst_n = 1;
    endtask
`endif

    initial begin
        rst_n = 1;
        idle();
        test_reset();
        test_basic();
        test_squash();
        test_full();
        test_wrap();
        test_flush();
        test_commit_resolve();
        test_reset_mid();
`ifdef FALCO_BUQ_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
